// File: rtl/mio_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mio_bus_arbiter_pkg
// Shared definitions for the MIO bus arbiter: FSM state encodings, owner
// encodings, the default abort read-data word and a grant-to-owner helper.
// No ports (package).
// ---------------------------------------------------------------------------
package mio_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Maps a one-hot grant vector {dma, cpu} to the owner encoding.
  function automatic logic grant_owner(input logic [1:0] grant);
    return (grant == 2'b10) ? OWN_DMA : OWN_CPU;
  endfunction

endpackage

// File: rtl/mio_bus_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// mio_bus_arbiter_rr_arb2
// Combinational two-way round-robin pick. On a tie the requester that did
// not win last time is chosen.
// Ports:
//   req   [1:0] in   request vector, bit0 = CPU, bit1 = DMA
//   last        in   owner of the previous grant (OWN_CPU / OWN_DMA)
//   grant [1:0] out  one-hot grant, 2'b00 when nobody requests
// ---------------------------------------------------------------------------
module mio_bus_arbiter_rr_arb2
  import mio_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // Round-robin selection between the two requesters.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == OWN_DMA) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mio_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mio_bus_arbiter
// Shares one memory/IO slave port between the CPU controller and a DMA
// master. One transfer per grant, round-robin on ties, with a watchdog that
// aborts a slave transfer that never acknowledges.
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   cpu_req/we/addr/wdata  in        CPU request, held until cpu_ready
//   cpu_rdata/cpu_ready    out       registered read data + 1-cycle pulse
//   dma_req/we/addr/wdata  in        DMA request, held until dma_ready
//   dma_rdata/dma_ready    out       registered read data + 1-cycle pulse
//   mem_req/we/addr/wdata  out       registered slave request, held to ack
//   mem_rdata/mem_ack      in        slave response, ack single cycle
//   owner                  out       0 = CPU, 1 = DMA (current/last grant)
//   timeout_err            out       sticky abort flag
//   err_clr                in        clears timeout_err
// ---------------------------------------------------------------------------
module mio_bus_arbiter
  import mio_bus_arbiter_pkg::*;
#(
  parameter int unsigned     AW       = 32,
  parameter int unsigned     DW       = 32,
  parameter int unsigned     TIMEOUT  = 15,
  parameter logic [DW-1:0]   ERR_DATA = DW'(ERR_DATA_DEFAULT)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          owner,
  output logic          timeout_err,
  input  logic          err_clr
);

  // Counter only needs to reach TIMEOUT-1.
  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e          state_q,     state_d;
  logic            mem_req_q,   mem_req_d;
  logic            mem_we_q,    mem_we_d;
  logic [AW-1:0]   mem_addr_q,  mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            owner_q,     owner_d;
  logic            last_q,      last_d;
  logic [CW-1:0]   count_q,     count_d;
  logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]   dma_rdata_q, dma_rdata_d;
  logic            cpu_ready_q, cpu_ready_d;
  logic            dma_ready_q, dma_ready_d;
  logic            err_q,       err_d;

  logic [1:0]      grant_s;
  logic [DW-1:0]   rsp_s;
  logic            err_set_s;
  logic            wd_hit_s;

  mio_bus_arbiter_rr_arb2 u_rr_arb2 (
    .req   ({dma_req, cpu_req}),
    .last  (last_q),
    .grant (grant_s)
  );

  // State and datapath registers; reset forces the port idle immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      owner_q     <= OWN_CPU;
      last_q      <= OWN_DMA;
      count_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      count_q     <= count_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      dma_ready_q <= dma_ready_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic: grant in IDLE, wait for ack or watchdog in XFER,
  // DONE is the one-cycle bubble during which the ready pulse is visible.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    owner_d     = owner_q;
    last_d      = last_q;
    count_d     = count_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    cpu_ready_d = 1'b0;
    dma_ready_d = 1'b0;
    err_set_s   = 1'b0;
    rsp_s       = mem_rdata;
    wd_hit_s    = (count_q == CW'(TIMEOUT - 1));

    case (state_q)
      ST_IDLE: begin
        if (grant_s != 2'b00) begin
          owner_d = grant_owner(grant_s);
          last_d  = grant_owner(grant_s);
          if (grant_owner(grant_s) == OWN_DMA) begin
            mem_we_d    = dma_we;
            mem_addr_d  = dma_addr;
            mem_wdata_d = dma_wdata;
          end else begin
            mem_we_d    = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
          end
          mem_req_d = 1'b1;
          count_d   = '0;
          state_d   = ST_XFER;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_XFER: begin
        count_d = count_q + CW'(1);
        // An ack in the watchdog's final cycle still counts as a completion.
        if (mem_ack) begin
          rsp_s = mem_rdata;
        end else begin
          rsp_s = ERR_DATA;
        end
        if (mem_ack || wd_hit_s) begin
          mem_req_d = 1'b0;
          err_set_s = ~mem_ack;
          state_d   = ST_DONE;
          if (owner_q == OWN_DMA) begin
            dma_rdata_d = rsp_s;
            dma_ready_d = 1'b1;
          end else begin
            cpu_rdata_d = rsp_s;
            cpu_ready_d = 1'b1;
          end
        end else begin
          state_d = ST_XFER;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // A watchdog abort in the same cycle as err_clr leaves the flag set.
    if (err_set_s) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  assign cpu_rdata   = cpu_rdata_q;
  assign cpu_ready   = cpu_ready_q;
  assign dma_rdata   = dma_rdata_q;
  assign dma_ready   = dma_ready_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign owner       = owner_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mio_bus_arbiter
// Directed bench for mio_bus_arbiter: a table of single-master transfers
// plus hand-written sequences for ties, watchdog abort, stray acks and
// reset in the middle of a transfer. Inputs change and outputs are sampled
// on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mio_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        cpu_ready, dma_ready;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        owner, timeout_err, err_clr;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        master;     // 0 = CPU, 1 = DMA
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;        // XFER cycles before the slave acks
    logic [31:0] srd;        // slave read data
    logic        exp_owner;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  mio_bus_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ready   (cpu_ready),
    .dma_req     (dma_req),
    .dma_we      (dma_we),
    .dma_addr    (dma_addr),
    .dma_wdata   (dma_wdata),
    .dma_rdata   (dma_rdata),
    .dma_ready   (dma_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .owner       (owner),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Serves one granted transfer: waits for the grant, checks the latched
  // request, scrambles the master's inputs, acks after dly cycles and checks
  // the ready pulse. Drops the master's request after ready.
  task automatic serve(input logic m, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int dly, input logic [31:0] srd,
                       input logic chk_rd, input logic [31:0] exp_rd, input int max_wait);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && n < max_wait);
    chk("grant", {31'd0, mem_req}, 32'd1);
    chk("owner", {31'd0, owner}, {31'd0, m});
    chk("mem_we", {31'd0, mem_we}, {31'd0, we});
    chk("mem_addr", mem_addr, addr);
    chk("mem_wdata", mem_wdata, wdata);
    if (m) begin
      dma_addr = ~dma_addr; dma_wdata = ~dma_wdata; dma_we = ~dma_we;
    end else begin
      cpu_addr = ~cpu_addr; cpu_wdata = ~cpu_wdata; cpu_we = ~cpu_we;
    end
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("hold_req", {31'd0, mem_req}, 32'd1);
      chk("hold_addr", mem_addr, addr);
      chk("hold_wdata", mem_wdata, wdata);
      chk("hold_we", {31'd0, mem_we}, {31'd0, we});
    end
    mem_ack = 1'b1;
    mem_rdata = srd;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    chk("done_req", {31'd0, mem_req}, 32'd0);
    chk("cpu_ready", {31'd0, cpu_ready}, {31'd0, ~m});
    chk("dma_ready", {31'd0, dma_ready}, {31'd0, m});
    if (chk_rd) begin
      if (m) chk("dma_rdata", dma_rdata, exp_rd);
      else   chk("cpu_rdata", cpu_rdata, exp_rd);
    end
    if (m) dma_req = 1'b0;
    else   cpu_req = 1'b0;
    @(negedge clk);
    chk("pulse_end", {30'd0, cpu_ready, dma_ready}, 32'd0);
  endtask

  // Both masters request together; 'first' must be served before the other.
  task automatic tie(input logic first);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hC000_0010; cpu_wdata = 32'h0;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'hD000_0020; dma_wdata = 32'h0BB0_0BB0;
    if (first == 1'b0) begin
      serve(1'b0, 1'b0, 32'hC000_0010, 32'h0, 0, 32'h1111_0001, 1'b1, 32'h1111_0001, 1);
      serve(1'b1, 1'b1, 32'hD000_0020, 32'h0BB0_0BB0, 1, 32'h0, 1'b0, 32'h0, 4);
    end else begin
      serve(1'b1, 1'b1, 32'hD000_0020, 32'h0BB0_0BB0, 0, 32'h0, 1'b0, 32'h0, 1);
      serve(1'b0, 1'b0, 32'hC000_0010, 32'h0, 1, 32'h2222_0002, 1'b1, 32'h2222_0002, 4);
    end
  endtask

  initial begin
    int n;
    vecs[0] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0000_0000,  2, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0000_0000,  0, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_3000, 32'h1111_2222,  1, 32'h0000_0055, 1'b0, 32'h0000_0000, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0100, 32'hA5A5_A5A5,  3, 32'h0000_0066, 1'b1, 32'h0000_0000, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_4000, 32'h0000_0000, 14, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_5000, 32'h0000_0000, 13, 32'h7777_8888, 1'b1, 32'h7777_8888, 1'b0};

    reset_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_owner", {31'd0, owner}, 32'd0);
    chk("rst_ready", {30'd0, cpu_ready, dma_ready}, 32'd0);
    chk("rst_err", {31'd0, timeout_err}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_dma_rdata", dma_rdata, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_mem_req", {31'd0, mem_req}, 32'd0);

    // Tie right after reset: CPU first, then DMA; repeated gives the same.
    tie(1'b0);
    tie(1'b0);

    // Table of single-master transfers.
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].master) begin
        dma_req = 1'b1; dma_we = vecs[v].we; dma_addr = vecs[v].addr; dma_wdata = vecs[v].wdata;
      end else begin
        cpu_req = 1'b1; cpu_we = vecs[v].we; cpu_addr = vecs[v].addr; cpu_wdata = vecs[v].wdata;
      end
      serve(vecs[v].exp_owner, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].dly,
            vecs[v].srd, ~vecs[v].we, vecs[v].exp_rdata, 1);
      chk("vec_err", {31'd0, timeout_err}, {31'd0, vecs[v].exp_err});
    end

    // Last grant went to DMA; a CPU-only transfer then makes DMA win the tie.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_7000; cpu_wdata = 32'h0;
    serve(1'b0, 1'b0, 32'h0000_7000, 32'h0, 0, 32'h3333_4444, 1'b1, 32'h3333_4444, 1);
    tie(1'b1);

    // Watchdog: slave never acks.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_6000; cpu_wdata = 32'h0;
    @(negedge clk);
    chk("to_grant", {31'd0, mem_req}, 32'd1);
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("to_cycles", n, 32'd15);
    chk("to_cpu_ready", {31'd0, cpu_ready}, 32'd1);
    chk("to_dma_ready", {31'd0, dma_ready}, 32'd0);
    chk("to_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("to_err_set", {31'd0, timeout_err}, 32'd1);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("to_pulse_end", {31'd0, cpu_ready}, 32'd0);
    repeat (3) @(negedge clk);
    chk("to_err_sticky", {31'd0, timeout_err}, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("to_err_clr", {31'd0, timeout_err}, 32'd0);

    // Stray ack while idle must be ignored.
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk("stray_ready", {30'd0, cpu_ready, dma_ready}, 32'd0);
    chk("stray_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("stray_req", {31'd0, mem_req}, 32'd0);

    // Reset in the middle of a DMA transfer.
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h0000_8000;
    @(negedge clk);
    chk("mid_grant", {31'd0, mem_req}, 32'd1);
    chk("mid_owner", {31'd0, owner}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
    chk("mid_rst_owner", {31'd0, owner}, 32'd0);
    chk("mid_rst_ready", {30'd0, cpu_ready, dma_ready}, 32'd0);
    chk("mid_rst_rdata", dma_rdata, 32'h0);
    dma_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_9000;
    serve(1'b0, 1'b0, 32'h0000_9000, 32'h0, 1, 32'h5A5A_0F0F, 1'b1, 32'h5A5A_0F0F, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
